pwm_channel: RTL and testbench

- Per-channel PWM/timer core that sits directly downstream of the Wishbone register file.
- Consumes one channel's ctrl, period, divisor and duty-cycle words and produces the PWM output waveform plus a period/expiry interrupt pulse.
- Instantiated num_ch times at top level; each instance's inputs are wired to that channel's four register-file entries.

---
 rtl/pwm_channel.sv | 156 +++++++++++++++
 tb/tb_pwm_channel.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_channel.sv
// Per-channel PWM / one-shot timer fed from the channel's ctrl, period, divisor and dc words.
// Define PWM_DEADTIME_EN to add the complementary o_pwm_n output with dead-time insertion.
module pwm_channel #(
    parameter int mem_width = 16,
    parameter int dead_cyc  = 2
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst,
    input  logic [mem_width-1:0] i_ctrl,
    input  logic [mem_width-1:0] i_period,
    input  logic [mem_width-1:0] i_divisor,
    input  logic [mem_width-1:0] i_dc,
    output logic                 o_pwm,
    output logic                 o_irq,
    output logic                 o_busy
`ifdef PWM_DEADTIME_EN
    ,
    output logic                 o_pwm_n
`endif
);

    localparam logic [mem_width-1:0] one = {{(mem_width-1){1'b0}}, 1'b1};

    logic en, one_shot, pol, irq_en;
    assign en       = i_ctrl[0];
    assign one_shot = i_ctrl[1];
    assign pol      = i_ctrl[2];
    assign irq_en   = i_ctrl[3];

    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^i_ctrl[mem_width-1:4];

    logic [mem_width-1:0] div_cnt, cnt, period_s, dc_s;
    logic [mem_width-1:0] div_cnt_d, cnt_d, period_d, dc_d;
    logic                 en_q, done, pwm_q;
    logic                 done_d, busy_d, irq_d, pwm_d;
    logic                 start, tick;

    assign start = en & ~en_q;

    always_comb begin
        div_cnt_d = div_cnt;
        cnt_d     = cnt;
        period_d  = period_s;
        dc_d      = dc_s;
        done_d    = done;
        busy_d    = o_busy;
        irq_d     = 1'b0;
        pwm_d     = pol;
        tick      = 1'b0;

        if (!en) begin
            div_cnt_d = '0;
            cnt_d     = '0;
            done_d    = 1'b0;
            busy_d    = 1'b0;
        end else if (start) begin
            period_d  = i_period;
            dc_d      = i_dc;
            div_cnt_d = '0;
            cnt_d     = '0;
            done_d    = 1'b0;
            busy_d    = 1'b1;
        end else begin
            // An expired one-shot stops counting until the next start event
            if (!done) begin
                tick      = (i_divisor <= one) || (div_cnt == i_divisor - one);
                div_cnt_d = tick ? '0 : div_cnt + one;
                if (tick && (period_s != '0)) begin
                    if (cnt == period_s - one) begin
                        cnt_d = '0;
                        irq_d = irq_en;
                        if (one_shot) begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end else begin
                            period_d = i_period;
                            dc_d     = i_dc;
                        end
                    end else begin
                        cnt_d = cnt + one;
                    end
                end
            end

            if (period_s == '0)
                pwm_d = pol;
            else if (one_shot)
                pwm_d = ~done ^ pol;
            else
                pwm_d = (cnt < dc_s) ^ pol;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst) begin
            div_cnt  <= '0;
            cnt      <= '0;
            period_s <= '0;
            dc_s     <= '0;
            en_q     <= 1'b0;
            done     <= 1'b0;
            pwm_q    <= 1'b0;
            o_irq    <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            div_cnt  <= div_cnt_d;
            cnt      <= cnt_d;
            period_s <= period_d;
            dc_s     <= dc_d;
            en_q     <= en;
            done     <= done_d;
            pwm_q    <= pwm_d;
            o_irq    <= irq_d;
            o_busy   <= busy_d;
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam int dt_w = (dead_cyc > 0) ? $clog2(dead_cyc + 1) : 1;
    localparam logic [dt_w-1:0] dt_load = dt_w'(dead_cyc);
    localparam logic [dt_w-1:0] dt_one  = dt_w'(1);

    logic [dt_w-1:0] dt_cnt;

    // Any change of the raw waveform parks both outputs idle for dead_cyc cycles;
    // going idle is therefore immediate, going active is delayed.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst) begin
            dt_cnt  <= '0;
            o_pwm   <= 1'b0;
            o_pwm_n <= 1'b0;
        end else if (!en) begin
            dt_cnt  <= '0;
            o_pwm   <= pol;
            o_pwm_n <= pol;
        end else if (pwm_d != pwm_q) begin
            dt_cnt  <= dt_load;
            o_pwm   <= pol;
            o_pwm_n <= pol;
        end else if (dt_cnt > dt_one) begin
            dt_cnt  <= dt_cnt - dt_one;
            o_pwm   <= pol;
            o_pwm_n <= pol;
        end else begin
            dt_cnt  <= '0;
            o_pwm   <= pwm_d;
            o_pwm_n <= (pwm_d == pol) ? ~pol : pol;
        end
    end
`else
    localparam int unused_dead_cyc = dead_cyc;
    assign o_pwm = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_channel.sv
// Directed bench for pwm_channel: continuous PWM, prescaling, shadowing, boundaries,
// one-shot expiry, reset and disable priority.
module tb_pwm_channel;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] ctrl, period, divisor, dc;
    logic         pwm, irq, busy;
`ifdef PWM_DEADTIME_EN
    logic         pwm_n;
`endif

    pwm_channel #(.mem_width(W), .dead_cyc(2)) dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (rst),
        .i_ctrl    (ctrl),
        .i_period  (period),
        .i_divisor (divisor),
        .i_dc      (dc),
        .o_pwm     (pwm),
        .o_irq     (irq),
        .o_busy    (busy)
`ifdef PWM_DEADTIME_EN
        ,
        .o_pwm_n   (pwm_n)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int hi_cnt, irq_cnt, first_irq, bad_shape;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Disable for two cycles, then raise enable; returns just after the start edge.
    task automatic start_ch(input logic [W-1:0] c);
        ctrl = '0;
        step(2);
        ctrl = c;
        step(1);
    endtask

    // Samples n cycles after the current point. With p > 0 the waveform is also
    // compared against the ideal: high when ((k-1)/d mod p) < h, inverted by pol.
    task automatic observe(input int n, input int d, input int p, input int h, input bit pol);
        hi_cnt    = 0;
        irq_cnt   = 0;
        first_irq = 0;
        bad_shape = 0;
        for (int k = 1; k <= n; k++) begin
            step(1);
            if (pwm) hi_cnt++;
            if (irq) begin
                irq_cnt++;
                if (first_irq == 0) first_irq = k;
            end
            if (p > 0 && pwm !== (((((k - 1) / d) % p) < h) ^ pol)) bad_shape++;
        end
    endtask

    initial begin
        rst = 1'b0; ctrl = '0; period = 16'd10; divisor = 16'd1; dc = 16'd3;
        step(3);
        check("rst_pwm", pwm, 0);
        check("rst_irq", irq, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        step(1);

        // continuous, divisor 1
        start_ch(16'h0009);
        check("a_busy_start", busy, 1);
        check("a_pwm_start", pwm, 0);
        observe(40, 1, 10, 3, 0);
        check("a_hi", hi_cnt, 12);
        check("a_irq", irq_cnt, 4);
        check("a_first_irq", first_irq, 10);
        check("a_shape", bad_shape, 0);
        check("a_busy", busy, 1);

        // continuous, divisor 4
        divisor = 16'd4;
        start_ch(16'h0009);
        observe(80, 4, 10, 3, 0);
        check("b_hi", hi_cnt, 24);
        check("b_irq", irq_cnt, 2);
        check("b_first_irq", first_irq, 40);
        check("b_shape", bad_shape, 0);

        // irq enable off
        divisor = 16'd1;
        start_ch(16'h0001);
        observe(20, 1, 10, 3, 0);
        check("noirq_irq", irq_cnt, 0);
        check("noirq_shape", bad_shape, 0);

        // duty change mid-period
        start_ch(16'h0009);
        observe(5, 1, 10, 3, 0);
        check("c_hi_first", hi_cnt, 3);
        dc = 16'd7;
        observe(5, 1, 0, 0, 0);
        check("c_hi_rest", hi_cnt, 0);
        check("c_wrap_irq", first_irq, 5);
        observe(10, 1, 0, 0, 0);
        check("c_hi_next", hi_cnt, 7);

        // boundaries, normal polarity
        dc = 16'd0;
        start_ch(16'h0009);
        observe(20, 1, 10, 0, 0);
        check("d_dc0_hi", hi_cnt, 0);
        check("d_dc0_irq", irq_cnt, 2);
        dc = 16'd12;
        start_ch(16'h0009);
        observe(20, 1, 10, 12, 0);
        check("d_dc12_hi", hi_cnt, 20);
        period = 16'd0; dc = 16'd3;
        start_ch(16'h0009);
        observe(20, 1, 0, 0, 0);
        check("d_p0_hi", hi_cnt, 0);
        check("d_p0_irq", irq_cnt, 0);
        check("d_p0_busy", busy, 1);

        // boundaries, inverted polarity
        period = 16'd10; dc = 16'd0;
        start_ch(16'h000D);
        observe(20, 1, 10, 0, 1);
        check("e_inv_dc0_hi", hi_cnt, 20);
        dc = 16'd12;
        start_ch(16'h000D);
        observe(20, 1, 10, 12, 1);
        check("e_inv_dc12_hi", hi_cnt, 0);
        period = 16'd0; dc = 16'd3;
        start_ch(16'h000D);
        observe(20, 1, 0, 0, 0);
        check("e_inv_p0_hi", hi_cnt, 20);
        check("e_inv_p0_irq", irq_cnt, 0);

        // period 1: wrap and irq every tick
        period = 16'd1; dc = 16'd1;
        start_ch(16'h0009);
        observe(10, 1, 1, 1, 0);
        check("p1_irq", irq_cnt, 10);
        check("p1_hi", hi_cnt, 10);

        // one-shot
        period = 16'd5; dc = 16'd3;
        start_ch(16'h000B);
        check("os_busy_start", busy, 1);
        observe(12, 1, 0, 0, 0);
        check("os_hi", hi_cnt, 5);
        check("os_irq", irq_cnt, 1);
        check("os_first_irq", first_irq, 5);
        check("os_busy_end", busy, 0);
        observe(20, 1, 0, 0, 0);
        check("os_idle_hi", hi_cnt, 0);
        check("os_idle_irq", irq_cnt, 0);
        start_ch(16'h000B);
        observe(12, 1, 0, 0, 0);
        check("os_re_hi", hi_cnt, 5);
        check("os_re_irq", irq_cnt, 1);

        // reset mid-period while output is high
        period = 16'd10; dc = 16'd3;
        start_ch(16'h0009);
        step(2);
        check("f_pre_pwm", pwm, 1);
        rst = 1'b0;
        step(1);
        check("f_rst_pwm", pwm, 0);
        check("f_rst_busy", busy, 0);
        rst = 1'b1; ctrl = '0;
        observe(10, 1, 0, 0, 0);
        check("f_hold_irq", irq_cnt, 0);
        check("f_hold_busy", busy, 0);
        start_ch(16'h0009);
        observe(20, 1, 10, 3, 0);
        check("f_resume_shape", bad_shape, 0);
        check("f_resume_irq", irq_cnt, 2);

        // disable in the wrap cycle suppresses the irq; idle level follows polarity
        start_ch(16'h0009);
        step(9);
        ctrl = 16'h0004;
        step(1);
        check("g_irq", irq, 0);
        check("g_busy", busy, 0);
        check("g_idle_pol", pwm, 1);
        ctrl = '0;
        step(1);
        check("g_idle_nopol", pwm, 0);
        start_ch(16'h0009);
        observe(10, 1, 0, 0, 0);
        check("g_resume_irq", first_irq, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
